// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the GMII transmit arbiter:
//   - eth_state_e       : transmit FSM states
//   - ETH_PREAMBLE_BYTE : preamble octet (0x55)
//   - ETH_SFD_BYTE      : start-of-frame delimiter octet (0xD5)
//   - sat_inc8          : saturating 8-bit increment used by the error counter
// -----------------------------------------------------------------------------
package eth_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      SFD  = 3'd2,
      DATA = 3'd3,
      IFG  = 3'd4
   } eth_state_e;

   localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;

   // Increment that sticks at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic. The grant is combinational from the
// requests; the pointer remembers which source was granted last and only
// moves when the owner accepts the grant.
// Ports:
//   clk      in  1  clock
//   rst_n    in  1  asynchronous active-low reset (pointer -> source 1)
//   i_req    in  2  request vector, bit i = source i
//   i_accept in  1  owner takes the current grant this cycle
//   o_gnt    out 2  one-hot grant (0 when no request)
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_gnt
);

   // 1 = source 1 was granted most recently, so source 0 wins the next tie
   logic r_last;

   // Grant selection: a lone request wins outright, a tie goes to the other source
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   // Pointer register, updated only when a grant is actually taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (i_accept && (o_gnt != 2'b00)) begin
         r_last <= o_gnt[1];
      end else begin
         r_last <= r_last;
      end
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
// Shares one GMII transmit interface between two frame sources. Generates
// preamble + SFD, streams the granted source's payload, enforces the
// inter-frame gap and aborts frames on underrun or over-length.
// Ports:
//   gmii_tx_clk in  1   transmit byte clock (only clock)
//   rst_n       in  1   asynchronous active-low reset
//   src_req     in  2   per-source frame request
//   src_gnt     out 2   one-hot grant, held for the whole frame
//   src_data    in  16  payload bytes, source i on [8i+7:8i]
//   src_valid   in  2   payload byte valid
//   src_last    in  2   final payload byte marker
//   src_ready   out 2   payload byte accept strobe (DATA state only)
//   gmii_tx_en  out 1   registered GMII transmit enable
//   gmii_txd    out 8   registered GMII transmit data (0 when not enabled)
//   frame_cnt   out 16  frames completed with last (wraps)
//   err_cnt     out 8   aborted frames (saturates at 255)
// -----------------------------------------------------------------------------
module eth_tx_arbiter
   import eth_pkg::*;
#(
   parameter int PREAMBLE_LEN = 7,
   parameter int IFG_LEN      = 12,
   parameter int MAX_LEN      = 1514
) (
   input  logic        gmii_tx_clk,
   input  logic        rst_n,
   input  logic [1:0]  src_req,
   output logic [1:0]  src_gnt,
   input  logic [15:0] src_data,
   input  logic [1:0]  src_valid,
   input  logic [1:0]  src_last,
   output logic [1:0]  src_ready,
   output logic        gmii_tx_en,
   output logic [7:0]  gmii_txd,
   output logic [15:0] frame_cnt,
   output logic [7:0]  err_cnt
);

   // Terminal values of the shared 12-bit cycle/byte counter
   localparam logic [11:0] PRE_LAST = 12'(PREAMBLE_LEN - 1);
   localparam logic [11:0] IFG_LAST = 12'(IFG_LEN - 1);
   localparam logic [11:0] LEN_LAST = 12'(MAX_LEN - 1);

   eth_state_e  r_state, w_state_nxt;
   logic [11:0] r_cnt, w_cnt_nxt;
   logic [1:0]  r_gnt, w_gnt_nxt;
   logic        r_tx_en, w_tx_en_nxt;
   logic [7:0]  r_txd, w_txd_nxt;
   logic [15:0] r_frame_cnt;
   logic [7:0]  r_err_cnt;
   logic        w_frame_inc, w_err_inc;
   logic [1:0]  w_arb_gnt;
   logic        w_arb_accept;
   logic [7:0]  w_sel_data;
   logic        w_sel_valid, w_sel_last;

   // Payload mux driven by the held one-hot grant
   assign w_sel_data   = r_gnt[1] ? src_data[15:8] : src_data[7:0];
   assign w_sel_valid  = |(src_valid & r_gnt);
   assign w_sel_last   = |(src_last & r_gnt);
   // Requests only matter in IDLE; the pointer moves on the grant edge
   assign w_arb_accept = (r_state == IDLE);

   rr_arb2 u_rr_arb2 (
      .clk      (gmii_tx_clk),
      .rst_n    (rst_n),
      .i_req    (src_req),
      .i_accept (w_arb_accept),
      .o_gnt    (w_arb_gnt)
   );

   // Next-state, next-output and ready decode for the transmit FSM
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gnt_nxt   = r_gnt;
      w_tx_en_nxt = 1'b0;
      w_txd_nxt   = 8'h00;
      w_frame_inc = 1'b0;
      w_err_inc   = 1'b0;
      src_ready   = 2'b00;
      case (r_state)
         IDLE: begin
            if (w_arb_gnt != 2'b00) begin
               w_gnt_nxt   = w_arb_gnt;
               w_cnt_nxt   = 12'd0;
               w_state_nxt = PRE;
            end else begin
               w_gnt_nxt   = 2'b00;
            end
         end
         PRE: begin
            w_tx_en_nxt = 1'b1;
            w_txd_nxt   = ETH_PREAMBLE_BYTE;
            if (r_cnt == PRE_LAST) begin
               w_cnt_nxt   = 12'd0;
               w_state_nxt = SFD;
            end else begin
               w_cnt_nxt   = r_cnt + 12'd1;
            end
         end
         SFD: begin
            w_tx_en_nxt = 1'b1;
            w_txd_nxt   = ETH_SFD_BYTE;
            w_cnt_nxt   = 12'd0;
            w_state_nxt = DATA;
         end
         DATA: begin
            src_ready = r_gnt;
            if (w_sel_valid) begin
               w_tx_en_nxt = 1'b1;
               w_txd_nxt   = w_sel_data;
               w_cnt_nxt   = r_cnt + 12'd1;
               if (w_sel_last) begin
                  // last on the MAX_LEN-th byte still counts as a good frame
                  w_frame_inc = 1'b1;
                  w_gnt_nxt   = 2'b00;
                  w_cnt_nxt   = 12'd0;
                  w_state_nxt = IFG;
               end else if (r_cnt == LEN_LAST) begin
                  // byte just accepted is the MAX_LEN-th: send it, then abort
                  w_err_inc   = 1'b1;
                  w_gnt_nxt   = 2'b00;
                  w_cnt_nxt   = 12'd0;
                  w_state_nxt = IFG;
               end else begin
                  w_state_nxt = DATA;
               end
            end else begin
               // underrun: nothing accepted, en drops on this edge
               w_err_inc   = 1'b1;
               w_gnt_nxt   = 2'b00;
               w_cnt_nxt   = 12'd0;
               w_state_nxt = IFG;
            end
         end
         IFG: begin
            if (r_cnt == IFG_LAST) begin
               w_cnt_nxt   = 12'd0;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt   = r_cnt + 12'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = 2'b00;
            w_cnt_nxt   = 12'd0;
         end
      endcase
   end

   // State, grant, GMII output and counter registers
   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= 12'd0;
         r_gnt       <= 2'b00;
         r_tx_en     <= 1'b0;
         r_txd       <= 8'h00;
         r_frame_cnt <= 16'd0;
         r_err_cnt   <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_gnt       <= w_gnt_nxt;
         r_tx_en     <= w_tx_en_nxt;
         r_txd       <= w_txd_nxt;
         r_frame_cnt <= w_frame_inc ? (r_frame_cnt + 16'd1) : r_frame_cnt;
         r_err_cnt   <= w_err_inc ? sat_inc8(r_err_cnt) : r_err_cnt;
      end
   end

   assign src_gnt    = r_gnt;
   assign gmii_tx_en = r_tx_en;
   assign gmii_txd   = r_txd;
   assign frame_cnt  = r_frame_cnt;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_arbiter
// Directed bench for eth_tx_arbiter. Two instances: default parameters and
// MAX_LEN=8 for the over-length case. Each source is a small byte-array model
// that advances when ready&valid at a rising edge. Inputs change and outputs
// are sampled on the falling edge; c = 0 is the first falling edge after the
// grant edge of a scenario.
// -----------------------------------------------------------------------------
module tb_eth_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  src_req, src_gnt, src_valid, src_last, src_ready;
   logic [15:0] src_data;
   logic        gmii_tx_en;
   logic [7:0]  gmii_txd;
   logic [15:0] frame_cnt;
   logic [7:0]  err_cnt;

   logic [1:0]  m_req, m_gnt, m_valid, m_last, m_ready;
   logic [15:0] m_data;
   logic        m_en;
   logic [7:0]  m_txd;
   logic [15:0] m_fc;
   logic [7:0]  m_ec;

   int n_checks = 0;
   int n_fail   = 0;

   // source models: 0,1 feed the main DUT, 2 feeds source 0 of the MAX_LEN=8 DUT
   logic [7:0] mem [3][16];
   logic       lst [3][16];
   int         len  [3] = '{0, 0, 0};
   int         base [3] = '{0, 0, 0};
   int         idx  [3] = '{0, 0, 0};
   logic       v [3];
   logic [7:0] d [3];
   logic       l [3];

   always #5 clk = ~clk;

   eth_tx_arbiter dut (
      .gmii_tx_clk (clk), .rst_n (rst_n),
      .src_req (src_req), .src_gnt (src_gnt), .src_data (src_data),
      .src_valid (src_valid), .src_last (src_last), .src_ready (src_ready),
      .gmii_tx_en (gmii_tx_en), .gmii_txd (gmii_txd),
      .frame_cnt (frame_cnt), .err_cnt (err_cnt)
   );

   eth_tx_arbiter #(.MAX_LEN(8)) dut_ml (
      .gmii_tx_clk (clk), .rst_n (rst_n),
      .src_req (m_req), .src_gnt (m_gnt), .src_data (m_data),
      .src_valid (m_valid), .src_last (m_last), .src_ready (m_ready),
      .gmii_tx_en (m_en), .gmii_txd (m_txd),
      .frame_cnt (m_fc), .err_cnt (m_ec)
   );

   always_comb begin
      for (int s = 0; s < 3; s++) begin
         int r;
         r    = idx[s] - base[s];
         v[s] = (r >= 0) && (r < len[s]);
         d[s] = v[s] ? mem[s][r[3:0]] : 8'h00;
         l[s] = v[s] && lst[s][r[3:0]];
      end
   end

   assign src_valid = {v[1], v[0]};
   assign src_data  = {d[1], d[0]};
   assign src_last  = {l[1], l[0]};
   assign m_valid   = {1'b0, v[2]};
   assign m_data    = {8'h00, d[2]};
   assign m_last    = {1'b0, l[2]};

   always @(posedge clk) begin
      if (src_ready[0] && src_valid[0]) idx[0] <= idx[0] + 1;
      if (src_ready[1] && src_valid[1]) idx[1] <= idx[1] + 1;
      if (m_ready[0] && m_valid[0])     idx[2] <= idx[2] + 1;
   end

   // n bytes counting up from b0; last_mask bit i marks byte i as last
   task automatic load(input int s, input int n, input logic [7:0] b0, input int last_mask);
      base[s] = idx[s];
      len[s]  = n;
      for (int i = 0; i < 16; i++) begin
         mem[s][i] = b0 + 8'(i);
         lst[s][i] = last_mask[i];
      end
   endtask

   // Expected {en, txd} at sample c for a frame granted at sample g with n bytes
   function automatic logic [8:0] exp_line(input int c, input int g, input int n, input logic [7:0] b0);
      if (c >= g + 1 && c <= g + 7)          return {1'b1, 8'h55};
      else if (c == g + 8)                   return {1'b1, 8'hD5};
      else if (c >= g + 9 && c < g + 9 + n)  return {1'b1, b0 + 8'(c - g - 9)};
      else                                   return 9'h000;
   endfunction

   task automatic do_reset();
      src_req = 2'b00;
      m_req   = 2'b00;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({gmii_tx_en, gmii_txd, src_gnt, src_ready, frame_cnt, err_cnt} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_main en=%b txd=%h gnt=%b rdy=%b fc=%0d ec=%0d, want all 0",
                  gmii_tx_en, gmii_txd, src_gnt, src_ready, frame_cnt, err_cnt);
      end
      n_checks++;
      if ({m_en, m_txd, m_gnt, m_ready, m_fc, m_ec} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_ml en=%b txd=%h gnt=%b fc=%0d ec=%0d, want all 0", m_en, m_txd, m_gnt, m_fc, m_ec);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({gmii_tx_en, src_gnt} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle en=%b gnt=%b, want 0/00", gmii_tx_en, src_gnt);
      end
   endtask

   task automatic test_single_frame();
      logic [8:0] e;
      do_reset();
      load(0, 4, 8'hA1, 32'h8);
      src_req = 2'b01;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         e = exp_line(c, 0, 4, 8'hA1);
         n_checks++;
         if ({gmii_tx_en, gmii_txd} !== e) begin
            n_fail++;
            $display("FAIL single c=%0d got en=%b txd=%h want en=%b txd=%h", c, gmii_tx_en, gmii_txd, e[8], e[7:0]);
         end
         if (c == 0) begin
            n_checks++;
            if (src_gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt got %b want 01", src_gnt); end
            src_req = 2'b00;
         end
         if (c == 9) begin
            n_checks++;
            if (src_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b want 01", src_ready); end
         end
         if (c == 13) begin
            n_checks++;
            if ({src_gnt, src_ready} !== 4'b0000) begin
               n_fail++; $display("FAIL single_release gnt=%b rdy=%b want 00/00", src_gnt, src_ready);
            end
         end
      end
      n_checks++;
      if (frame_cnt !== 16'd1 || err_cnt !== 8'd0) begin
         n_fail++; $display("FAIL single_cnt fc=%0d ec=%0d want 1/0", frame_cnt, err_cnt);
      end
   endtask

   task automatic test_tie();
      logic [8:0] e;
      do_reset();
      load(0, 2, 8'h11, 32'h2);
      load(1, 2, 8'h21, 32'h2);
      src_req = 2'b11;
      for (int c = 0; c < 57; c++) begin
         @(negedge clk);
         e = exp_line(c, 0, 2, 8'h11) | exp_line(c, 23, 2, 8'h21) | exp_line(c, 46, 1, 8'h31);
         n_checks++;
         if ({gmii_tx_en, gmii_txd} !== e) begin
            n_fail++;
            $display("FAIL tie c=%0d got en=%b txd=%h want en=%b txd=%h", c, gmii_tx_en, gmii_txd, e[8], e[7:0]);
         end
         if (c == 0 || c == 22 || c == 23 || c == 45 || c == 46) begin
            logic [1:0] eg;
            eg = (c == 0 || c == 46) ? 2'b01 : (c == 23) ? 2'b10 : 2'b00;
            n_checks++;
            if (src_gnt !== eg) begin n_fail++; $display("FAIL tie_gnt c=%0d got %b want %b", c, src_gnt, eg); end
         end
         if (c == 0) src_req = 2'b10;
         if (c == 23) begin
            load(0, 1, 8'h31, 32'h1);
            src_req = 2'b11;
         end
         if (c == 46) src_req = 2'b00;
      end
      n_checks++;
      if (frame_cnt !== 16'd3 || err_cnt !== 8'd0) begin
         n_fail++; $display("FAIL tie_cnt fc=%0d ec=%0d want 3/0", frame_cnt, err_cnt);
      end
   endtask

   task automatic test_underrun();
      logic [8:0] e;
      do_reset();
      load(1, 3, 8'hC1, 32'h0);
      src_req = 2'b10;
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         e = exp_line(c, 0, 3, 8'hC1) | exp_line(c, 25, 1, 8'hD1);
         n_checks++;
         if ({gmii_tx_en, gmii_txd} !== e) begin
            n_fail++;
            $display("FAIL underrun c=%0d got en=%b txd=%h want en=%b txd=%h", c, gmii_tx_en, gmii_txd, e[8], e[7:0]);
         end
         if (c == 12) begin
            n_checks++;
            if (src_gnt !== 2'b00 || err_cnt !== 8'd1 || frame_cnt !== 16'd0) begin
               n_fail++; $display("FAIL underrun_abort gnt=%b ec=%0d fc=%0d want 00/1/0", src_gnt, err_cnt, frame_cnt);
            end
            load(1, 1, 8'hD1, 32'h1);
         end
         if (c == 24 || c == 25) begin
            n_checks++;
            if (src_gnt !== ((c == 25) ? 2'b10 : 2'b00)) begin
               n_fail++; $display("FAIL underrun_regrant c=%0d got %b", c, src_gnt);
            end
         end
         if (c == 25) src_req = 2'b00;
      end
      n_checks++;
      if (frame_cnt !== 16'd1 || err_cnt !== 8'd1) begin
         n_fail++; $display("FAIL underrun_cnt fc=%0d ec=%0d want 1/1", frame_cnt, err_cnt);
      end
   endtask

   task automatic test_overlength();
      logic [8:0] e;
      do_reset();
      load(2, 10, 8'h40, 32'h0);
      m_req = 2'b01;
      for (int c = 0; c < 31; c++) begin
         @(negedge clk);
         e = exp_line(c, 0, 8, 8'h40);
         n_checks++;
         if ({m_en, m_txd} !== e) begin
            n_fail++;
            $display("FAIL overlen c=%0d got en=%b txd=%h want en=%b txd=%h", c, m_en, m_txd, e[8], e[7:0]);
         end
         if (c == 0) begin
            n_checks++;
            if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL overlen_gnt got %b want 01", m_gnt); end
            m_req = 2'b00;
         end
         if (c == 16) begin
            n_checks++;
            if (m_ready !== 2'b00 || m_gnt !== 2'b00) begin
               n_fail++; $display("FAIL overlen_stop rdy=%b gnt=%b want 00/00", m_ready, m_gnt);
            end
         end
      end
      n_checks++;
      if (m_ec !== 8'd1 || m_fc !== 16'd0 || (idx[2] - base[2]) != 8) begin
         n_fail++; $display("FAIL overlen_cnt ec=%0d fc=%0d taken=%0d want 1/0/8", m_ec, m_fc, idx[2] - base[2]);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] e;
      do_reset();
      load(0, 8, 8'h01, 32'hAA);
      load(1, 1, 8'h61, 32'h1);
      src_req = 2'b01;
      for (int c = 0; c < 103; c++) begin
         @(negedge clk);
         e = exp_line(c, 0, 2, 8'h01) | exp_line(c, 23, 2, 8'h03) | exp_line(c, 46, 2, 8'h05)
           | exp_line(c, 69, 1, 8'h61) | exp_line(c, 91, 2, 8'h07);
         n_checks++;
         if ({gmii_tx_en, gmii_txd} !== e) begin
            n_fail++;
            $display("FAIL b2b c=%0d got en=%b txd=%h want en=%b txd=%h", c, gmii_tx_en, gmii_txd, e[8], e[7:0]);
         end
         if (c == 23 || c == 46 || c == 69 || c == 91) begin
            n_checks++;
            if (src_gnt !== ((c == 69) ? 2'b10 : 2'b01)) begin
               n_fail++; $display("FAIL b2b_gnt c=%0d got %b", c, src_gnt);
            end
         end
         if (c == 50) src_req = 2'b11;
         if (c == 69) src_req = 2'b01;
         if (c == 91) src_req = 2'b00;
      end
      n_checks++;
      if (frame_cnt !== 16'd5 || err_cnt !== 8'd0) begin
         n_fail++; $display("FAIL b2b_cnt fc=%0d ec=%0d want 5/0", frame_cnt, err_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [8:0] e;
      repeat (20) @(negedge clk);
      n_checks++;
      if (frame_cnt !== 16'd5) begin n_fail++; $display("FAIL rst_pre fc=%0d want 5", frame_cnt); end
      load(0, 8, 8'hE0, 32'h80);
      src_req = 2'b01;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         e = exp_line(c, 0, 8, 8'hE0);
         n_checks++;
         if ({gmii_tx_en, gmii_txd} !== e) begin
            n_fail++;
            $display("FAIL rstmid c=%0d got en=%b txd=%h want en=%b txd=%h", c, gmii_tx_en, gmii_txd, e[8], e[7:0]);
         end
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({gmii_tx_en, gmii_txd, src_gnt, src_ready, frame_cnt, err_cnt} !== 36'h0) begin
         n_fail++;
         $display("FAIL rst_async en=%b txd=%h gnt=%b rdy=%b fc=%0d ec=%0d want all 0",
                  gmii_tx_en, gmii_txd, src_gnt, src_ready, frame_cnt, err_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      load(0, 1, 8'h71, 32'h1);
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         e = exp_line(c, 0, 1, 8'h71);
         n_checks++;
         if ({gmii_tx_en, gmii_txd} !== e) begin
            n_fail++;
            $display("FAIL rst_after c=%0d got en=%b txd=%h want en=%b txd=%h", c, gmii_tx_en, gmii_txd, e[8], e[7:0]);
         end
         if (c == 0) begin
            n_checks++;
            if (src_gnt !== 2'b01) begin n_fail++; $display("FAIL rst_regrant got %b want 01", src_gnt); end
            src_req = 2'b00;
         end
      end
      n_checks++;
      if (frame_cnt !== 16'd1 || err_cnt !== 8'd0) begin
         n_fail++; $display("FAIL rst_cnt fc=%0d ec=%0d want 1/0", frame_cnt, err_cnt);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      src_req = 2'b00;
      m_req   = 2'b00;
      test_reset();
      test_single_frame();
      test_tie();
      test_underrun();
      test_overlength();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares one GMII transmit interface between two frame sources, e.g. UDP and ARP engines, using round-robin arbitration.
- Sits directly upstream of the RGMII transmit converter and runs in the gmii_tx_clk domain.
- Generates preamble and SFD, streams the granted source's payload and enforces the inter-frame gap.
- Aborts frames on source underrun or over-length.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD (1..15).
- IFG_LEN, 12, idle cycles with gmii_tx_en low after every frame or abort (1..255).
- MAX_LEN, 1514, maximum payload bytes per frame before forced abort (1..4095).

Ports:
- gmii_tx_clk  in  1  transmit byte clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- src_req  in  2  per-source frame request; bit i = source i.
- src_gnt  out  2  one-hot grant; held for the whole frame.
- src_data  in  16  payload bytes; source i on bits [8i+7:8i].
- src_valid  in  2  payload byte valid.
- src_last  in  2  marks the final payload byte; qualified by valid and ready.
- src_ready  out  2  payload byte accept strobe.
- gmii_tx_en  out  1  GMII transmit enable (registered).
- gmii_txd  out  8  GMII transmit data (registered).
- frame_cnt  out  16  frames completed with src_last; wraps.
- err_cnt  out  8  aborted frames (underrun or over-length); saturates at 255.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = 1 so source 0 wins the first tie. Reset asserted mid-frame drops gmii_tx_en immediately (asynchronous); no IFG is owed after reset.
- States: IDLE, PRE, SFD, DATA, IFG.
- Output timing: gmii_tx_en/gmii_txd are registered from the current state's cycle, so the output lags state by exactly one cycle.
- IDLE:
  - gmii_tx_en = 0.
  - If exactly one src_req bit is high, grant that source.
  - If both are high, grant the source other than the last granted one, then update the pointer.
  - On the grant edge: src_gnt set one-hot, state -> PRE, counter cleared.
  - src_req is sampled only in IDLE. Pulses outside IDLE are ignored. Deasserting req after grant does not end the frame.
- PRE: PREAMBLE_LEN cycles, each registers en=1, txd=0x55; then -> SFD.
- SFD: 1 cycle registers en=1, txd=0xD5; then -> DATA with the byte counter cleared.
- DATA:
  - src_ready = src_gnt (combinational on state). The non-granted ready is always 0.
  - Each cycle with valid high registers en=1, txd=data and increments the 12-bit byte counter.
  - Accepted byte with last: frame_cnt++, src_gnt cleared on the same edge, -> IFG.
  - Valid low in any DATA cycle (underrun): registers en=0, err_cnt++, gnt cleared, -> IFG. The byte is not accepted.
  - Accepted byte that is the MAX_LEN-th without last: byte is transmitted, then err_cnt++, gnt cleared, -> IFG.
  - Last on exactly the MAX_LEN-th byte counts as a good frame.
- IFG:
  - en=0 for IFG_LEN cycles, then -> IDLE.
  - First gmii_tx_en rise of the next frame is IFG_LEN+2 cycles after the last enabled output cycle: 1 cycle in IDLE, 1 cycle in PRE to register.
- Latency: req sampled at edge k → gnt high after edge k; gmii_tx_en high from edge k+1.
  - Payload byte n appears on gmii_txd one cycle after its accept.
  - Minimum frame overhead: PREAMBLE_LEN+1 cycles.
- gmii_txd is 0 whenever gmii_tx_en is 0.
- err_cnt saturates: no increment at 255. frame_cnt wraps 0xFFFF -> 0.

Decomposition:
- Package eth_pkg: state enum (IDLE, PRE, SFD, DATA, IFG), constants ETH_PREAMBLE_BYTE=8'h55, ETH_SFD_BYTE=8'hD5.
- One natural sub-module, rr_arb2: 2-way round-robin grant logic with the pointer register, update on a grant-accept strobe.
- Payload mux, FSM and counters stay in eth_tx_arbiter.

Test Plan:
- Single frame: src0 req + 4 bytes A1 A2 A3 A4 (last on A4), valid continuous → txd 55×7, D5, A1..A4 with en high 12 consecutive cycles; then en low ≥12 cycles; frame_cnt=1.
- Tie: both req high in same cycle after reset → src0 granted first. src1 is granted at the IDLE after IFG, and txd carries src1 data. Third tie → src0.
- Underrun: src1 drops valid after 3 bytes → en falls the cycle after the gap, gnt cleared, err_cnt=1, frame_cnt unchanged, IFG of 12 then next frame.
- Over-length: MAX_LEN=8 override, source streams 10 bytes with no last → exactly 8 payload bytes on txd, then en=0, err_cnt=1.
- Back-to-back: src0 holds req continuously for 3 frames → each frame separated by exactly IFG_LEN+1 en-low cycles. src1 req inserted mid-frame is granted before src0's next frame.
- Reset mid-DATA: rst_n low during byte 5 → en/txd/gnt/ready go 0 asynchronously, counters 0. After release, first req is granted from IDLE with no IFG delay.
